sram_arbiter: RTL and testbench

- Two-port arbiter sharing the single SRAM command interface between the CPU-side SRAM cache (port 0) and a DMA/video requester (port 1).
- Sits between the cache's memory command port and the SRAM controller. Each slave port uses the same strobe/wait protocol as the SRAM controller.
- Registered master outputs. Round-robin grant with one transaction in flight at a time.

---
 rtl/sram_arbiter_pkg.sv | 16 +
 rtl/sram_arb_pick.sv | 30 +++
 rtl/sram_arbiter.sv | 125 ++++++++++++
 tb/tb_sram_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the two-port SRAM command arbiter: FSM states,
// port index constants and default bus widths.
package sram_arbiter_pkg;

   localparam int ADDR_W_DEF = 17;
   localparam int DATA_W_DEF = 32;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_DMA = 1'b1;

   typedef enum logic {
      StIdle = 1'b0,
      StBusy = 1'b1
   } state_t;

endpackage

// File: rtl/sram_arb_pick.sv
// Two-way grant picker. Round-robin on ties by default; defining
// SRAM_ARBITER_FIXED_PRIO_EN makes the cache port always win ties.
module sram_arb_pick
   import sram_arbiter_pkg::*;
(
   input  logic [1:0] i_req,
   input  logic       i_lastGrant,
   output logic       o_grant
);

`ifdef SRAM_ARBITER_FIXED_PRIO_EN
   logic w_unused;
   assign w_unused = i_lastGrant;

   always_comb begin
      o_grant = i_req[PORT_CPU] ? PORT_CPU : PORT_DMA;
   end
`else
   // On a tie the port that was not served most recently wins.
   always_comb begin
      o_grant = PORT_CPU;
      if (i_req[PORT_CPU] && i_req[PORT_DMA]) begin
         o_grant = ~i_lastGrant;
      end else if (i_req[PORT_DMA]) begin
         o_grant = PORT_DMA;
      end
   end
`endif

endmodule

// File: rtl/sram_arbiter.sv
// Shares one SRAM controller command port between the cache (port 0) and a
// DMA/video requester (port 1); optional SRAM_ARBITER_FIXED_PRIO_EN.
module sram_arbiter
   import sram_arbiter_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic                clk,
   input  logic                reset,

   input  logic [ADDR_W-1:0]   s0_addr,
   input  logic [DATA_W-1:0]   s0_wrdata,
   input  logic [DATA_W/8-1:0] s0_bytesel,
   input  logic                s0_wren,
   input  logic                s0_strobe,
   output logic                s0_wait,
   output logic [DATA_W-1:0]   s0_rddata,

   input  logic [ADDR_W-1:0]   s1_addr,
   input  logic [DATA_W-1:0]   s1_wrdata,
   input  logic [DATA_W/8-1:0] s1_bytesel,
   input  logic                s1_wren,
   input  logic                s1_strobe,
   output logic                s1_wait,
   output logic [DATA_W-1:0]   s1_rddata,

   output logic [ADDR_W-1:0]   m_addr,
   output logic [DATA_W-1:0]   m_wrdata,
   output logic [DATA_W/8-1:0] m_bytesel,
   output logic                m_wren,
   output logic                m_strobe,
   input  logic                m_wait,
   input  logic [DATA_W-1:0]   m_rddata
);

   state_t r_state;
   state_t w_stateNext;

   logic r_grant;
   logic r_lastGrant;
   logic r_dropped;

   logic [1:0] w_req;
   logic       w_pick;
   logic       w_launch;
   logic       w_done;
   logic       w_ownerStrobe;
   logic       w_ack;

   assign w_req         = {s1_strobe, s0_strobe};
   assign w_ownerStrobe = (r_grant == PORT_DMA) ? s1_strobe : s0_strobe;

   sram_arb_pick u_pick (
      .i_req       (w_req),
      .i_lastGrant (r_lastGrant),
      .o_grant     (w_pick)
   );

   always_comb begin
      w_stateNext = r_state;
      w_launch    = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         StIdle: begin
            if (|w_req) begin
               w_launch    = 1'b1;
               w_stateNext = StBusy;
            end
         end
         StBusy: begin
            if (!m_wait) begin
               w_done      = 1'b1;
               w_stateNext = StIdle;
            end
         end
         default: w_stateNext = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // A requester that lets go of its strobe mid-transaction forfeits the
   // completion; the SRAM access itself still runs to the end.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_addr      <= '0;
         m_wrdata    <= '0;
         m_bytesel   <= '0;
         m_wren      <= 1'b0;
         m_strobe    <= 1'b0;
         r_grant     <= PORT_CPU;
         r_lastGrant <= PORT_DMA;
         r_dropped   <= 1'b0;
      end else if (w_launch) begin
         m_addr      <= (w_pick == PORT_DMA) ? s1_addr    : s0_addr;
         m_wrdata    <= (w_pick == PORT_DMA) ? s1_wrdata  : s0_wrdata;
         m_bytesel   <= (w_pick == PORT_DMA) ? s1_bytesel : s0_bytesel;
         m_wren      <= (w_pick == PORT_DMA) ? s1_wren    : s0_wren;
         m_strobe    <= 1'b1;
         r_grant     <= w_pick;
         r_dropped   <= 1'b0;
      end else if (w_done) begin
         m_strobe    <= 1'b0;
         r_lastGrant <= r_grant;
         r_dropped   <= 1'b0;
      end else if ((r_state == StBusy) && !w_ownerStrobe) begin
         r_dropped   <= 1'b1;
      end
   end

   assign w_ack = (r_state == StBusy) && !m_wait && w_ownerStrobe && !r_dropped;

   assign s0_wait   = !(w_ack && (r_grant == PORT_CPU));
   assign s1_wait   = !(w_ack && (r_grant == PORT_DMA));
   assign s0_rddata = m_rddata;
   assign s1_rddata = m_rddata;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed sequences, a per-cycle
// vector table and randomized requesters checked against a transaction model.
module tb_sram_arbiter;

   localparam int AW = 17;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] s0_addr, s1_addr, m_addr;
   logic [DW-1:0] s0_wrdata, s1_wrdata, m_wrdata;
   logic [3:0]    s0_bytesel, s1_bytesel, m_bytesel;
   logic          s0_wren, s1_wren, m_wren;
   logic          s0_strobe, s1_strobe, m_strobe;
   logic          s0_wait, s1_wait, m_wait;
   logic [DW-1:0] s0_rddata, s1_rddata, m_rddata;

   int checks = 0;
   int errors = 0;

   sram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk        (clk),
      .reset      (reset),
      .s0_addr    (s0_addr),
      .s0_wrdata  (s0_wrdata),
      .s0_bytesel (s0_bytesel),
      .s0_wren    (s0_wren),
      .s0_strobe  (s0_strobe),
      .s0_wait    (s0_wait),
      .s0_rddata  (s0_rddata),
      .s1_addr    (s1_addr),
      .s1_wrdata  (s1_wrdata),
      .s1_bytesel (s1_bytesel),
      .s1_wren    (s1_wren),
      .s1_strobe  (s1_strobe),
      .s1_wait    (s1_wait),
      .s1_rddata  (s1_rddata),
      .m_addr     (m_addr),
      .m_wrdata   (m_wrdata),
      .m_bytesel  (m_bytesel),
      .m_wren     (m_wren),
      .m_strobe   (m_strobe),
      .m_wait     (m_wait),
      .m_rddata   (m_rddata)
   );

   always #5 clk = ~clk;

   // Transaction-level reference: which port owns the SRAM, what it asked
   // for, who was served last and whether the owner has walked away.
   bit            mdlBusy;
   int            mdlOwner;
   int            mdlLast;
   bit            mdlDropped;
   logic [AW-1:0] mdlAddr;
   logic [DW-1:0] mdlData;
   logic [3:0]    mdlBe;
   logic          mdlWren;

   function automatic bit strobeOf(input int p);
      return (p == 1) ? s1_strobe : s0_strobe;
   endfunction

   function automatic int pickRef();
`ifdef SRAM_ARBITER_FIXED_PRIO_EN
      return s0_strobe ? 0 : 1;
`else
      if (s0_strobe && s1_strobe) return 1 - mdlLast;
      return s0_strobe ? 0 : 1;
`endif
   endfunction

   task automatic modelReset();
      mdlBusy = 0; mdlOwner = 0; mdlLast = 1; mdlDropped = 0;
   endtask

   task automatic modelAdvance();
      if (!mdlBusy) begin
         if (s0_strobe || s1_strobe) begin
            mdlOwner   = pickRef();
            mdlAddr    = (mdlOwner == 1) ? s1_addr    : s0_addr;
            mdlData    = (mdlOwner == 1) ? s1_wrdata  : s0_wrdata;
            mdlBe      = (mdlOwner == 1) ? s1_bytesel : s0_bytesel;
            mdlWren    = (mdlOwner == 1) ? s1_wren    : s0_wren;
            mdlBusy    = 1;
            mdlDropped = 0;
         end
      end else begin
         if (!strobeOf(mdlOwner)) mdlDropped = 1;
         if (!m_wait) begin
            mdlBusy = 0;
            mdlLast = mdlOwner;
         end
      end
   endtask

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic modelCheck();
      bit ack;
      ack = mdlBusy && !m_wait && strobeOf(mdlOwner) && !mdlDropped;
      checkOutput("mdl_m_strobe", m_strobe, mdlBusy);
      checkOutput("mdl_s0_wait", s0_wait, !(ack && mdlOwner == 0));
      checkOutput("mdl_s1_wait", s1_wait, !(ack && mdlOwner == 1));
      checkOutput("mdl_s0_rddata", s0_rddata, m_rddata);
      checkOutput("mdl_s1_rddata", s1_rddata, m_rddata);
      if (mdlBusy) begin
         checkOutput("mdl_m_addr", m_addr, mdlAddr);
         checkOutput("mdl_m_wrdata", m_wrdata, mdlData);
         checkOutput("mdl_m_bytesel", m_bytesel, mdlBe);
         checkOutput("mdl_m_wren", m_wren, mdlWren);
      end
   endtask

   // Drive one cycle's request/response pins at the falling edge, then
   // compare against the model once the combinational outputs settle.
   task automatic applyStimulus(input bit st0, input bit st1, input bit mw, input logic [DW-1:0] rd);
      s0_strobe = st0;
      s1_strobe = st1;
      m_wait    = mw;
      m_rddata  = rd;
      #1;
      modelCheck();
   endtask

   task automatic tick();
      modelAdvance();
      @(negedge clk);
   endtask

   task automatic setPort(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [3:0] be, input logic we);
      if (p == 0) begin
         s0_addr = a; s0_wrdata = d; s0_bytesel = be; s0_wren = we;
      end else begin
         s1_addr = a; s1_wrdata = d; s1_bytesel = be; s1_wren = we;
      end
   endtask

   task automatic doReset();
      reset = 1'b0;
      s0_strobe = 0; s1_strobe = 0; m_wait = 1; m_rddata = '0;
      setPort(0, '0, '0, 4'hF, 0);
      setPort(1, '0, '0, 4'hF, 0);
      modelReset();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   typedef struct {
      bit s0Str;
      bit s1Str;
      bit mWait;
      bit expMStrobe;
      bit expS0Wait;
      bit expS1Wait;
      int expOwner;
   } vec_t;

   vec_t vecs[16];

   initial begin
      int cnt0, cnt1;
      bit served;
      bit active[2];
      bit release_[2];

      // Table for continuous dual requests with an SRAM that never stalls:
      // even cycles arbitrate, odd cycles complete.
      for (int i = 0; i < 16; i++) begin
         int owner;
`ifdef SRAM_ARBITER_FIXED_PRIO_EN
         owner = 0;
`else
         owner = (i / 2) % 2;
`endif
         vecs[i].s0Str      = 1;
         vecs[i].s1Str      = 1;
         vecs[i].mWait      = 0;
         vecs[i].expOwner   = owner;
         vecs[i].expMStrobe = (i % 2 == 1);
         vecs[i].expS0Wait  = !((i % 2 == 1) && owner == 0);
         vecs[i].expS1Wait  = !((i % 2 == 1) && owner == 1);
      end

      reset = 1'b0;
      s0_strobe = 0; s1_strobe = 0; m_wait = 1; m_rddata = '0;
      setPort(0, '0, '0, 4'hF, 0);
      setPort(1, '0, '0, 4'hF, 0);
      modelReset();
      @(negedge clk);
      #1;
      checkOutput("rst_m_strobe", m_strobe, 0);
      checkOutput("rst_m_wren", m_wren, 0);
      checkOutput("rst_m_addr", m_addr, 0);
      checkOutput("rst_m_wrdata", m_wrdata, 0);
      checkOutput("rst_m_bytesel", m_bytesel, 0);
      checkOutput("rst_s0_wait", s0_wait, 1);
      checkOutput("rst_s1_wait", s1_wait, 1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      $display("[TB] single read on port 0");
      setPort(0, 17'h00123, 32'h0, 4'hF, 0);
      applyStimulus(1, 0, 1, 32'h0);
      checkOutput("t1_idle_strobe", m_strobe, 0);
      tick();
      applyStimulus(1, 0, 1, 32'h0);
      checkOutput("t1_m_strobe", m_strobe, 1);
      checkOutput("t1_m_addr", m_addr, 17'h00123);
      checkOutput("t1_m_wren", m_wren, 0);
      tick();
      applyStimulus(1, 0, 1, 32'h0);
      checkOutput("t1_s0_wait_hold", s0_wait, 1);
      tick();
      applyStimulus(1, 0, 0, 32'hDEADBEEF);
      checkOutput("t1_s0_wait", s0_wait, 0);
      checkOutput("t1_s0_rddata", s0_rddata, 32'hDEADBEEF);
      tick();
      applyStimulus(0, 0, 1, 32'h0);
      checkOutput("t1_strobe_off", m_strobe, 0);
      tick();

      $display("[TB] simultaneous writes from reset");
      doReset();
      setPort(0, 17'h00010, 32'h11111111, 4'hF, 1);
      setPort(1, 17'h1FFFF, 32'hA5A55A5A, 4'h3, 1);
      applyStimulus(1, 1, 1, 32'h0);
      tick();
      applyStimulus(1, 1, 1, 32'h0);
      checkOutput("t2_p0_addr", m_addr, 17'h00010);
      checkOutput("t2_p0_data", m_wrdata, 32'h11111111);
      checkOutput("t2_s1_stall_a", s1_wait, 1);
      tick();
      applyStimulus(1, 1, 0, 32'h0);
      checkOutput("t2_s0_done", s0_wait, 0);
      checkOutput("t2_s1_stall_b", s1_wait, 1);
      tick();
      applyStimulus(0, 1, 1, 32'h0);
      checkOutput("t2_s1_stall_c", s1_wait, 1);
      tick();
      applyStimulus(0, 1, 0, 32'h0);
      checkOutput("t2_p1_addr", m_addr, 17'h1FFFF);
      checkOutput("t2_p1_be", m_bytesel, 4'h3);
      checkOutput("t2_p1_wren", m_wren, 1);
      checkOutput("t2_s1_done", s1_wait, 0);
      tick();
      applyStimulus(0, 0, 1, 32'h0);
      tick();

      $display("[TB] continuous requests from both ports");
      doReset();
      setPort(0, 17'h00AAA, 32'h0, 4'hF, 0);
      setPort(1, 17'h15555, 32'h0, 4'hF, 0);
      cnt0 = 0; cnt1 = 0;
      for (int i = 0; i < 16; i++) begin
         applyStimulus(vecs[i].s0Str, vecs[i].s1Str, vecs[i].mWait, 32'h1000 + i);
         checkOutput($sformatf("vec%0d_m_strobe", i), m_strobe, vecs[i].expMStrobe);
         checkOutput($sformatf("vec%0d_s0_wait", i), s0_wait, vecs[i].expS0Wait);
         checkOutput($sformatf("vec%0d_s1_wait", i), s1_wait, vecs[i].expS1Wait);
         if (vecs[i].expMStrobe)
            checkOutput($sformatf("vec%0d_m_addr", i), m_addr,
                        (vecs[i].expOwner == 1) ? 17'h15555 : 17'h00AAA);
         if (!s0_wait) cnt0++;
         if (!s1_wait) cnt1++;
         tick();
      end
`ifdef SRAM_ARBITER_FIXED_PRIO_EN
      checkOutput("vec_done0", cnt0, 8);
      checkOutput("vec_done1", cnt1, 0);
`else
      checkOutput("vec_done0", cnt0, 4);
      checkOutput("vec_done1", cnt1, 4);
`endif
      served = 0;
      for (int i = 0; i < 8 && !served; i++) begin
         applyStimulus(0, 1, 0, 32'h0);
         if (!s1_wait) served = 1;
         tick();
      end
      checkOutput("s1_served_after_s0_drop", served, 1);
      applyStimulus(0, 0, 1, 32'h0);
      tick();

      $display("[TB] asynchronous reset while busy");
      doReset();
      setPort(0, 17'h00042, 32'h0, 4'hF, 0);
      setPort(1, 17'h0BEEF, 32'h0, 4'hF, 0);
      applyStimulus(1, 0, 1, 32'h0);
      tick();
      applyStimulus(1, 1, 1, 32'h0);
      #2 reset = 1'b0;
      #1;
      checkOutput("arst_m_strobe", m_strobe, 0);
      checkOutput("arst_s0_wait", s0_wait, 1);
      checkOutput("arst_s1_wait", s1_wait, 1);
      modelReset();
      @(negedge clk);
      reset = 1'b1;
      applyStimulus(0, 1, 1, 32'h0);
      tick();
      applyStimulus(0, 1, 0, 32'h5A5A0001);
      checkOutput("arst_s1_strobe", m_strobe, 1);
      checkOutput("arst_s1_addr", m_addr, 17'h0BEEF);
      checkOutput("arst_s1_done", s1_wait, 0);
      tick();
      applyStimulus(0, 0, 1, 32'h0);
      tick();

      $display("[TB] granted port drops its strobe");
      doReset();
      setPort(1, 17'h00777, 32'h0, 4'hF, 0);
      applyStimulus(0, 1, 1, 32'h0);
      tick();
      applyStimulus(0, 1, 1, 32'h0);
      tick();
      applyStimulus(0, 0, 1, 32'h0);
      tick();
      applyStimulus(0, 0, 0, 32'h0);
      checkOutput("drop_s1_wait", s1_wait, 1);
      checkOutput("drop_s0_wait", s0_wait, 1);
      checkOutput("drop_m_strobe", m_strobe, 1);
      tick();
      applyStimulus(0, 0, 1, 32'h0);
      checkOutput("drop_idle", m_strobe, 0);
      tick();

      $display("[TB] randomized requesters");
      doReset();
      active[0] = 0; active[1] = 0;
      release_[0] = 0; release_[1] = 0;
      for (int c = 0; c < 400; c++) begin
         bit st[2];
         for (int p = 0; p < 2; p++) begin
            if (release_[p]) active[p] = 0;
            release_[p] = 0;
            if (!active[p] && $urandom_range(0, 2) == 0) begin
               setPort(p, AW'($urandom), $urandom, 4'($urandom), 1'($urandom));
               active[p] = 1;
            end
            st[p] = active[p];
         end
         applyStimulus(st[0], st[1], $urandom_range(0, 9) < 6, $urandom);
         if (!s0_wait) release_[0] = 1;
         if (!s1_wait) release_[1] = 1;
         tick();
      end

      $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
